// File: rtl/twiddle_gen_if.sv
// Twiddle generator handshake bundle: index request in, complex twiddle out.
// The inv signal exists only when TWIDDLE_GEN_INV_EN is defined.
interface twiddle_gen_if #(
    parameter int LOG_N    = 7,
    parameter int TW_WIDTH = 16
);
    logic                en;
    logic                in_valid;
    logic [LOG_N-1:0]    addr;
`ifdef TWIDDLE_GEN_INV_EN
    logic                inv;
`endif
    logic                out_valid;
    logic [TW_WIDTH-1:0] data_r;
    logic [TW_WIDTH-1:0] data_i;

`ifdef TWIDDLE_GEN_INV_EN
    modport master (output en, in_valid, addr, inv, input out_valid, data_r, data_i);
    modport slave  (input en, in_valid, addr, inv, output out_valid, data_r, data_i);
`else
    modport master (output en, in_valid, addr, input out_valid, data_r, data_i);
    modport slave  (input en, in_valid, addr, output out_valid, data_r, data_i);
`endif
endinterface

// File: rtl/twiddle_gen.sv
// twiddle_gen: W_N^n = cos(-2*pi*n/N) + j*sin(-2*pi*n/N) for N = 2^LOG_N.
// Three enabled stages: S1 folds n into quadrant + offset, S2 reads a
// quarter-wave magnitude table twice, S3 restores signs per quadrant.
// The quarter-wave table Q[k] = round(sin(2*pi*k/N) * 2^(TW_WIDTH-1)),
// k = 0..N/4, is computed at elaboration with the same rounding rule the
// table script uses, so no external image file is needed.
// Optional feature macro: TWIDDLE_GEN_INV_EN adds an inv input that selects
// the conjugate (IFFT) twiddle.
module twiddle_gen #(
    parameter int LOG_N    = 7,
    parameter int TW_WIDTH = 16,
    parameter bit ZERO_W0  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    twiddle_gen_if.slave bus
);
    localparam int R_W = LOG_N - 2;
    localparam int QTR = 1 << R_W;

    localparam logic [R_W:0]        QTR_IDX  = (R_W + 1)'(QTR);
    localparam logic [TW_WIDTH-1:0] FULL     = TW_WIDTH'(1) << (TW_WIDTH - 1);
    localparam logic [TW_WIDTH-1:0] POS_MAX  = FULL - TW_WIDTH'(1);
    localparam real                 PI       = 3.14159265358979323846;
    localparam real                 SCALE    = 1 << (TW_WIDTH - 1);

    // Quarter-wave magnitude table, constant contents.
    logic [TW_WIDTH-1:0] rom [0:QTR];
    for (genvar k = 0; k <= QTR; k++) begin : g_rom
        localparam int MAG = $rtoi($sin(2.0 * PI * k / (4.0 * QTR)) * SCALE + 0.5);
        assign rom[k] = TW_WIDTH'(MAG);
    end

    logic in_inv;
`ifdef TWIDDLE_GEN_INV_EN
    assign in_inv = bus.inv;
`else
    assign in_inv = 1'b0;
`endif

    // Negation is plain two's complement (0 -> 0, full -> most negative);
    // the positive full-scale magnitude is clipped to the largest code.
    function automatic logic [TW_WIDTH-1:0] apply_sign(
        input logic [TW_WIDTH-1:0] mag,
        input logic                neg
    );
        if (neg)
            return -mag;
        else if (mag == FULL)
            return POS_MAX;
        else
            return mag;
    endfunction

    logic [R_W:0]        s1_a, s1_b;
    logic [1:0]          s1_q;
    logic                s1_zero, s1_inv, s1_valid;

    logic [TW_WIDTH-1:0] s2_mag_a, s2_mag_b;
    logic [1:0]          s2_q;
    logic                s2_zero, s2_inv, s2_valid;

    // S1 fold: quadrant, offset and its mirror within the quadrant.
    always_ff @(posedge clock) begin
        // NOTE: registered state uses non-blocking assignment so every stage
        // samples the previous stage's value from before this clock edge.
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (bus.en) begin
            s1_valid <= bus.in_valid;
            s1_q     <= bus.addr[LOG_N-1 -: 2];
            s1_a     <= {1'b0, bus.addr[R_W-1:0]};
            s1_b     <= QTR_IDX - {1'b0, bus.addr[R_W-1:0]};
            s1_zero  <= (bus.addr == '0);
            s1_inv   <= in_inv;
        end
    end

    // S2 table read: both magnitudes needed by the unfold.
    always_ff @(posedge clock) begin
        // NOTE: only valid bits are reset; the data fields are qualified by
        // them, so leaving them unreset is safe and keeps the datapath lean.
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (bus.en) begin
            s2_valid <= s1_valid;
            s2_mag_a <= rom[s1_a];
            s2_mag_b <= rom[s1_b];
            s2_q     <= s1_q;
            s2_zero  <= s1_zero;
            s2_inv   <= s1_inv;
        end
    end

    logic [TW_WIDTH-1:0] re_mag, im_mag, re_val, im_val;
    logic                re_neg, im_neg;

    // S3 quadrant sign/swap: q0 (+B,-A), q1 (-A,-B), q2 (-B,+A), q3 (+A,+B).
    always_comb begin
        // NOTE: every output of this block is assigned on every pass, which
        // is what keeps it purely combinational (no latch).
        re_mag = s2_q[0] ? s2_mag_a : s2_mag_b;
        im_mag = s2_q[0] ? s2_mag_b : s2_mag_a;
        re_neg = s2_q[1] ^ s2_q[0];
        im_neg = ~s2_q[1] ^ s2_inv;
        re_val = apply_sign(re_mag, re_neg);
        im_val = apply_sign(im_mag, im_neg);
    end

    // S3 output register: data loads only for a valid index.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.data_r    <= '0;
            bus.data_i    <= '0;
        end else if (bus.en) begin
            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                if (ZERO_W0 && s2_zero) begin
                    bus.data_r <= '0;
                    bus.data_i <= '0;
                end else begin
                    bus.data_r <= re_val;
                    bus.data_i <= im_val;
                end
            end
        end
    end
endmodule
